// File: rtl/issue_dispatch.sv
// Buffered single-issue dispatch stage: issue queue, ROB/LSB credit counters,
// RS slot allocation with a one-cycle reservation mask, registered dispatch outputs.
module issue_dispatch #(
    parameter int IQ_DEPTH    = 4,
    parameter int RS_SIZE     = 16,
    parameter int LSB_SIZE    = 16,
    parameter int ROB_SIZE    = 16,
    parameter int ID_W        = 6,
    parameter int PAYLOAD_W   = 64,
    parameter int LAST_MEM_ID = 13
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         rdy_in,
    input  logic                         flush_in,
    input  logic                         if_valid_in,
    input  logic [ID_W-1:0]              if_id_in,
    input  logic [4:0]                   if_rd_in,
    input  logic                         if_wb_in,
    input  logic [PAYLOAD_W-1:0]         if_payload_in,
    output logic                         iq_full_out,
    input  logic [RS_SIZE-1:0]           rs_busy_in,
    input  logic                         rob_commit_in,
    input  logic                         lsb_release_in,
    output logic                         rs_en_out,
    output logic                         lsb_en_out,
    output logic                         rob_en_out,
    output logic                         regfile_en_out,
    output logic [$clog2(RS_SIZE)-1:0]   rs_pos_out,
    output logic [$clog2(LSB_SIZE)-1:0]  lsb_pos_out,
    output logic [$clog2(ROB_SIZE)-1:0]  rob_pos_out,
    output logic [ID_W-1:0]              id_out,
    output logic [4:0]                   rd_out,
    output logic [PAYLOAD_W-1:0]         payload_out,
    output logic [31:0]                  stall_cnt_out
);
    localparam int IQ_AW  = $clog2(IQ_DEPTH);
    localparam int IQ_CW  = $clog2(IQ_DEPTH + 1);
    localparam int RS_AW  = $clog2(RS_SIZE);
    localparam int LSB_AW = $clog2(LSB_SIZE);
    localparam int LSB_CW = $clog2(LSB_SIZE + 1);
    localparam int ROB_AW = $clog2(ROB_SIZE);
    localparam int ROB_CW = $clog2(ROB_SIZE + 1);

    function automatic logic [IQ_AW-1:0] iq_next(input logic [IQ_AW-1:0] p);
        return (p == IQ_AW'(IQ_DEPTH - 1)) ? '0 : p + IQ_AW'(1);
    endfunction

    function automatic logic [ROB_AW-1:0] rob_next(input logic [ROB_AW-1:0] p);
        return (p == ROB_AW'(ROB_SIZE - 1)) ? '0 : p + ROB_AW'(1);
    endfunction

    function automatic logic [LSB_AW-1:0] lsb_next(input logic [LSB_AW-1:0] p);
        return (p == LSB_AW'(LSB_SIZE - 1)) ? '0 : p + LSB_AW'(1);
    endfunction

    function automatic logic [RS_AW-1:0] lowest_set(input logic [RS_SIZE-1:0] v);
        logic [RS_AW-1:0] idx;
        idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (v[i]) idx = RS_AW'(i);
        end
        return idx;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [ID_W-1:0]      iq_id      [IQ_DEPTH];
    logic [4:0]           iq_rd      [IQ_DEPTH];
    logic                 iq_wb      [IQ_DEPTH];
    logic [PAYLOAD_W-1:0] iq_payload [IQ_DEPTH];

    logic [IQ_AW-1:0]   head, tail;
    logic [IQ_CW-1:0]   iq_cnt;
    logic [ROB_CW-1:0]  rob_cnt;
    logic [LSB_CW-1:0]  lsb_cnt;
    logic [ROB_AW-1:0]  rob_tail;
    logic [LSB_AW-1:0]  lsb_tail;
    logic [RS_SIZE-1:0] resv_mask;
    logic [31:0]        stall_cnt;

    logic               iq_empty, head_mem, can_disp, dispatch, push, head_stall;
    logic               rob_dec, lsb_dec;
    logic [RS_SIZE-1:0] rs_free;
    logic [RS_AW-1:0]   rs_slot;

    assign iq_empty    = (iq_cnt == '0);
    assign iq_full_out = (iq_cnt == IQ_CW'(IQ_DEPTH));
    assign head_mem    = (iq_id[head] <= ID_W'(LAST_MEM_ID));

    // The RS busy bitmap lags a dispatch by one cycle; the reservation mask hides that slot.
    assign rs_free = ~rs_busy_in & ~resv_mask;
    assign rs_slot = lowest_set(rs_free);

    assign can_disp   = !iq_empty && (rob_cnt < ROB_CW'(ROB_SIZE)) &&
                        (head_mem ? (lsb_cnt < LSB_CW'(LSB_SIZE)) : (|rs_free));
    assign dispatch   = rdy_in && !flush_in && can_disp;
    assign push       = rdy_in && !flush_in && if_valid_in && !iq_full_out;
    assign head_stall = rdy_in && !flush_in && !iq_empty && !can_disp;
    assign rob_dec    = rob_commit_in && (rob_cnt != '0);
    assign lsb_dec    = lsb_release_in && (lsb_cnt != '0);

    always_ff @(posedge clk_in) begin
        if (push) begin
            iq_id[tail]      <= if_id_in;
            iq_rd[tail]      <= if_rd_in;
            iq_wb[tail]      <= if_wb_in;
            iq_payload[tail] <= if_payload_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head      <= '0;
            tail      <= '0;
            iq_cnt    <= '0;
            rob_cnt   <= '0;
            lsb_cnt   <= '0;
            rob_tail  <= '0;
            lsb_tail  <= '0;
            resv_mask <= '0;
            stall_cnt <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                head      <= '0;
                tail      <= '0;
                iq_cnt    <= '0;
                rob_cnt   <= '0;
                lsb_cnt   <= '0;
                rob_tail  <= '0;
                lsb_tail  <= '0;
                resv_mask <= '0;
            end else begin
                if (push) tail <= iq_next(tail);
                if (dispatch) head <= iq_next(head);
                iq_cnt  <= iq_cnt + IQ_CW'(push) - IQ_CW'(dispatch);
                rob_cnt <= rob_cnt + ROB_CW'(dispatch) - ROB_CW'(rob_dec);
                lsb_cnt <= lsb_cnt + LSB_CW'(dispatch && head_mem) - LSB_CW'(lsb_dec);
                if (dispatch) rob_tail <= rob_next(rob_tail);
                if (dispatch && head_mem) lsb_tail <= lsb_next(lsb_tail);
                resv_mask <= (dispatch && !head_mem) ? (RS_SIZE'(1) << rs_slot) : '0;
                if (head_stall) stall_cnt <= sat_inc(stall_cnt);
            end
        end
    end

    // ---- p1: registered dispatch outputs ----
    logic                 vld_p1, mem_p1, rf_p1;
    logic [RS_AW-1:0]     rs_pos_p1;
    logic [LSB_AW-1:0]    lsb_pos_p1;
    logic [ROB_AW-1:0]    rob_pos_p1;
    logic [ID_W-1:0]      id_p1;
    logic [4:0]           rd_p1;
    logic [PAYLOAD_W-1:0] payload_p1;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            vld_p1     <= 1'b0;
            mem_p1     <= 1'b0;
            rf_p1      <= 1'b0;
            rs_pos_p1  <= '0;
            lsb_pos_p1 <= '0;
            rob_pos_p1 <= '0;
            id_p1      <= '0;
            rd_p1      <= '0;
            payload_p1 <= '0;
        end else begin
            vld_p1 <= dispatch;
            if (dispatch) begin
                mem_p1     <= head_mem;
                rf_p1      <= iq_wb[head] && (iq_rd[head] != 5'd0);
                rs_pos_p1  <= rs_slot;
                lsb_pos_p1 <= lsb_tail;
                rob_pos_p1 <= rob_tail;
                id_p1      <= iq_id[head];
                rd_p1      <= iq_rd[head];
                payload_p1 <= iq_payload[head];
            end
        end
    end

    assign rob_en_out     = vld_p1;
    assign rs_en_out      = vld_p1 && !mem_p1;
    assign lsb_en_out     = vld_p1 && mem_p1;
    assign regfile_en_out = vld_p1 && rf_p1;
    assign rs_pos_out     = rs_pos_p1;
    assign lsb_pos_out    = lsb_pos_p1;
    assign rob_pos_out    = rob_pos_p1;
    assign id_out         = id_p1;
    assign rd_out         = rd_p1;
    assign payload_out    = payload_p1;
    assign stall_cnt_out  = stall_cnt;
endmodule

// File: tb/tb_issue_dispatch.sv
// Bench for issue_dispatch: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_issue_dispatch;
    localparam int IQ_DEPTH    = 4;
    localparam int RS_SIZE     = 16;
    localparam int LSB_SIZE    = 16;
    localparam int ROB_SIZE    = 16;
    localparam int LAST_MEM_ID = 13;

    logic        clk = 1'b0;
    logic        rst, rdy, flush, if_valid, if_wb, rob_commit, lsb_release;
    logic [5:0]  if_id;
    logic [4:0]  if_rd;
    logic [63:0] if_payload;
    logic [15:0] rs_busy;
    logic        iq_full, rs_en, lsb_en, rob_en, rf_en;
    logic [3:0]  rs_pos, lsb_pos, rob_pos;
    logic [5:0]  id_o;
    logic [4:0]  rd_o;
    logic [63:0] pl_o;
    logic [31:0] stall;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    issue_dispatch dut (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .flush_in(flush),
        .if_valid_in(if_valid), .if_id_in(if_id), .if_rd_in(if_rd), .if_wb_in(if_wb),
        .if_payload_in(if_payload), .iq_full_out(iq_full), .rs_busy_in(rs_busy),
        .rob_commit_in(rob_commit), .lsb_release_in(lsb_release),
        .rs_en_out(rs_en), .lsb_en_out(lsb_en), .rob_en_out(rob_en), .regfile_en_out(rf_en),
        .rs_pos_out(rs_pos), .lsb_pos_out(lsb_pos), .rob_pos_out(rob_pos),
        .id_out(id_o), .rd_out(rd_o), .payload_out(pl_o), .stall_cnt_out(stall)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        rst = 1'b0; rdy = 1'b1; flush = 1'b0; if_valid = 1'b0; if_id = '0; if_rd = '0;
        if_wb = 1'b0; if_payload = '0; rs_busy = '0; rob_commit = 1'b0; lsb_release = 1'b0;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_push(input int id, input int rd, input bit wb);
        if_valid = 1'b1; if_id = 6'(id); if_rd = 5'(rd); if_wb = wb;
        if_payload = {$urandom, $urandom};
    endtask

    // Reference model: queue of pending entries plus integer credit bookkeeping.
    typedef struct { logic [5:0] id; logic [4:0] rd; logic wb; logic [63:0] pl; } ent_t;
    ent_t        mq[$];
    int          m_rob_cnt, m_lsb_cnt, m_rob_tail, m_lsb_tail, m_resv;
    longint      m_stall;
    logic        e_rs_en, e_lsb_en, e_rob_en, e_rf_en;
    int          e_rs_pos, e_lsb_pos, e_rob_pos;
    logic [5:0]  e_id;
    logic [4:0]  e_rd;
    logic [63:0] e_pl;

    task automatic model_clear();
        mq.delete();
        m_rob_cnt = 0; m_lsb_cnt = 0; m_rob_tail = 0; m_lsb_tail = 0; m_resv = -1;
    endtask

    task automatic model_step();
        ent_t e, n;
        bit   disp, mem, rob_dec, lsb_dec;
        int   slot;
        e_rs_en = 0; e_lsb_en = 0; e_rob_en = 0; e_rf_en = 0;
        if (rst) begin
            model_clear();
            m_stall = 0;
            e_rs_pos = 0; e_lsb_pos = 0; e_rob_pos = 0; e_id = '0; e_rd = '0; e_pl = '0;
            return;
        end
        if (!rdy) return;
        if (flush) begin
            model_clear();
            return;
        end
        disp = 0; mem = 0; slot = -1;
        if (mq.size() > 0) begin
            e = mq[0];
            mem = (int'(e.id) <= LAST_MEM_ID);
            for (int i = 0; i < RS_SIZE; i++)
                if (slot < 0 && !rs_busy[i] && i != m_resv) slot = i;
            disp = (m_rob_cnt < ROB_SIZE) && (mem ? (m_lsb_cnt < LSB_SIZE) : (slot >= 0));
            if (!disp && m_stall < 64'hFFFF_FFFF) m_stall++;
        end
        if (if_valid && mq.size() < IQ_DEPTH) begin
            n.id = if_id; n.rd = if_rd; n.wb = if_wb; n.pl = if_payload;
            mq.push_back(n);
        end
        rob_dec = rob_commit && m_rob_cnt > 0;
        lsb_dec = lsb_release && m_lsb_cnt > 0;
        if (disp) begin
            void'(mq.pop_front());
            e_rob_en = 1; e_rs_en = !mem; e_lsb_en = mem; e_rf_en = e.wb && e.rd != 0;
            e_rob_pos = m_rob_tail; e_id = e.id; e_rd = e.rd; e_pl = e.pl;
            if (mem) e_lsb_pos = m_lsb_tail; else e_rs_pos = slot;
            m_rob_tail = (m_rob_tail + 1) % ROB_SIZE;
            if (mem) m_lsb_tail = (m_lsb_tail + 1) % LSB_SIZE;
        end
        m_resv = (disp && !mem) ? slot : -1;
        m_rob_cnt = m_rob_cnt + int'(disp) - int'(rob_dec);
        m_lsb_cnt = m_lsb_cnt + int'(disp && mem) - int'(lsb_dec);
    endtask

    typedef struct { logic [5:0] id; logic [4:0] rd; logic wb; logic rs_en, lsb_en, rf_en; } vec_t;
    vec_t tbl[6];

    task automatic fill_test(input bit mem);
        int         pulses;
        logic [3:0] last_pos;
        string      tg;
        tg = mem ? "lsbfill" : "robfill";
        do_reset();
        pulses = 0; last_pos = '0;
        rob_commit = mem;
        for (int n = 1; n <= 30; n++) begin
            set_push(mem ? (n % 14) : (20 + n), n, 1'b1);
            tick();
            if (rob_en) begin
                pulses++;
                last_pos = mem ? lsb_pos : rob_pos;
            end
        end
        if_valid = 1'b0; rob_commit = 1'b0;
        chk({tg, " pulses"}, 64'(pulses), 16);
        chk({tg, " last pos"}, last_pos, 15);
        chk({tg, " iq_full"}, iq_full, 1);
        chk({tg, " stall_cnt"}, stall, 13);
        if (mem) lsb_release = 1'b1; else rob_commit = 1'b1;
        tick();
        lsb_release = 1'b0; rob_commit = 1'b0;
        chk({tg, " no same-cycle credit"}, rob_en, 0);
        chk({tg, " stall after credit"}, stall, 14);
        tick();
        chk({tg, " resume rob_en"}, rob_en, 1);
        chk({tg, " resume id"}, id_o, mem ? 3 : 37);
        chk({tg, " resume rob_pos"}, rob_pos, 0);
        if (mem) begin
            chk({tg, " resume lsb_en"}, lsb_en, 1);
            chk({tg, " resume lsb_pos"}, lsb_pos, 0);
        end else begin
            chk({tg, " resume rs_en"}, rs_en, 1);
        end
        chk({tg, " full cleared"}, iq_full, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] pl_exp;
        int          p_pos[3], p_step[3], np, pend_slot;
        bit          pend_v;

        tbl[0] = '{6'd20, 5'd3,  1'b1, 1'b1, 1'b0, 1'b1};
        tbl[1] = '{6'd5,  5'd0,  1'b1, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{6'd13, 5'd7,  1'b0, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{6'd14, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{6'd63, 5'd31, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[5] = '{6'd0,  5'd1,  1'b1, 1'b0, 1'b1, 1'b1};

        do_reset();
        chk("reset rob_en", rob_en, 0);
        chk("reset rs_en", rs_en, 0);
        chk("reset lsb_en", lsb_en, 0);
        chk("reset rf_en", rf_en, 0);
        chk("reset positions", {rs_pos, lsb_pos, rob_pos}, 0);
        chk("reset fields", {id_o, rd_o}, 0);
        chk("reset payload", pl_o, 0);
        chk("reset iq_full", iq_full, 0);
        chk("reset stall", stall, 0);

        for (int i = 0; i < 6; i++) begin
            do_reset();
            set_push(tbl[i].id, tbl[i].rd, tbl[i].wb);
            pl_exp = if_payload;
            tick();
            if_valid = 1'b0;
            chk($sformatf("vec%0d no early pulse", i), rob_en, 0);
            tick();
            chk($sformatf("vec%0d rob_en", i), rob_en, 1);
            chk($sformatf("vec%0d rs_en", i), rs_en, tbl[i].rs_en);
            chk($sformatf("vec%0d lsb_en", i), lsb_en, tbl[i].lsb_en);
            chk($sformatf("vec%0d rf_en", i), rf_en, tbl[i].rf_en);
            chk($sformatf("vec%0d rob_pos", i), rob_pos, 0);
            chk($sformatf("vec%0d slot", i), tbl[i].lsb_en ? lsb_pos : rs_pos, 0);
            chk($sformatf("vec%0d id", i), id_o, tbl[i].id);
            chk($sformatf("vec%0d rd", i), rd_o, tbl[i].rd);
            chk($sformatf("vec%0d payload", i), pl_o, pl_exp);
            tick();
            chk($sformatf("vec%0d single pulse", i), rob_en, 0);
        end

        // Back-to-back non-mem dispatch; the RS model marks a slot busy one cycle after its pulse.
        do_reset();
        np = 0; pend_v = 0; pend_slot = 0;
        for (int s = 0; s < 6; s++) begin
            if (s < 3) set_push(21 + s, 1, 1'b1); else if_valid = 1'b0;
            tick();
            if (pend_v) rs_busy[pend_slot] = 1'b1;
            pend_v = rs_en; pend_slot = int'(rs_pos);
            if (rs_en && np < 3) begin
                p_pos[np] = int'(rs_pos); p_step[np] = s; np++;
            end
        end
        chk("b2b pulse count", 64'(np), 3);
        for (int k = 0; k < 3; k++) begin
            if (k < np) begin
                chk($sformatf("b2b rs_pos %0d", k), 64'(p_pos[k]), 64'(k));
                chk($sformatf("b2b cycle %0d", k), 64'(p_step[k]), 64'(k + 1));
            end
        end

        fill_test(1'b0);
        fill_test(1'b1);

        // Flush with rob_cnt=5 and three stalled entries.
        do_reset();
        for (int n = 0; n < 5; n++) begin
            set_push(20 + n, 2, 1'b1);
            tick();
        end
        if_valid = 1'b0;
        tick();
        rs_busy = '1;
        for (int n = 0; n < 3; n++) begin
            set_push(30 + n, 2, 1'b1);
            tick();
        end
        if_valid = 1'b0;
        chk("flush pre stall", stall, 2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush no rob_en", rob_en, 0);
        chk("flush no rs_en", rs_en, 0);
        chk("flush iq_full", iq_full, 0);
        chk("flush keeps stall", stall, 2);
        rs_busy = '0;
        tick();
        chk("flush queue empty", rob_en, 0);
        set_push(40, 4, 1'b1);
        tick();
        if_valid = 1'b0;
        tick();
        chk("post-flush rob_en", rob_en, 1);
        chk("post-flush rob_pos", rob_pos, 0);
        chk("post-flush rs_pos", rs_pos, 0);
        chk("post-flush id", id_o, 40);

        // rdy_in low freezes the stage, including the reservation mask.
        do_reset();
        set_push(40, 9, 1'b1);
        tick();
        set_push(41, 9, 1'b1);
        tick();
        if_valid = 1'b0;
        chk("rdy first pulse", rob_en, 1);
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("rdy low no pulse %0d", k), rob_en, 0);
            chk($sformatf("rdy low stall %0d", k), stall, 0);
        end
        rdy = 1'b1;
        tick();
        chk("rdy resume rob_en", rob_en, 1);
        chk("rdy resume id", id_o, 41);
        chk("rdy resume rob_pos", rob_pos, 1);
        chk("rdy resume rs_pos", rs_pos, 1);

        // Mid-stream reset drops the in-flight pulse and the queue.
        do_reset();
        set_push(50, 5, 1'b1);
        tick();
        if_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midreset pulse dropped", rob_en, 0);
        chk("midreset iq_full", iq_full, 0);
        tick();
        chk("midreset queue dropped", rob_en, 0);

        // Randomized traffic against the reference model.
        do_reset();
        model_clear();
        m_stall = 0;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            rdy = ($urandom_range(0, 9) != 0);
            flush = ($urandom_range(0, 39) == 0);
            if_valid = ($urandom_range(0, 9) < 6);
            if_id = 6'($urandom_range(0, 63));
            if_rd = 5'($urandom_range(0, 31));
            if_wb = 1'($urandom_range(0, 1));
            if_payload = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: rs_busy = '0;
                1: rs_busy = 16'($urandom & $urandom);
                2: rs_busy = 16'($urandom | $urandom);
                default: rs_busy = '1;
            endcase
            rob_commit = ($urandom_range(0, 9) < 4);
            lsb_release = ($urandom_range(0, 9) < 3);
            model_step();
            tick();
            chk("rnd rob_en", rob_en, e_rob_en);
            chk("rnd rs_en", rs_en, e_rs_en);
            chk("rnd lsb_en", lsb_en, e_lsb_en);
            chk("rnd rf_en", rf_en, e_rf_en);
            chk("rnd iq_full", iq_full, mq.size() == IQ_DEPTH);
            chk("rnd stall", stall, 64'(m_stall));
            if (e_rob_en) begin
                chk("rnd rob_pos", rob_pos, 64'(e_rob_pos));
                chk("rnd id", id_o, e_id);
                chk("rnd rd", rd_o, e_rd);
                chk("rnd payload", pl_o, e_pl);
            end
            if (e_rs_en) chk("rnd rs_pos", rs_pos, 64'(e_rs_pos));
            if (e_lsb_en) chk("rnd lsb_pos", lsb_pos, 64'(e_lsb_pos));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
